// File: rtl/tenkey_debounce.sv
// Ten-key switch debouncer: synchronizes raw switches, accepts a stable pattern,
// and emits one registered pulse per press (or multi_err for chorded keys).
module tenkey_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sw,
    output logic [9:0] tenkey,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       multi_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    state_t           state, state_nxt;
    logic [9:0]       sw_meta, sync;
    logic [9:0]       snapshot, snapshot_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;
    logic             snap_onehot;
    logic [3:0]       snap_index;
    logic [9:0]       tenkey_nxt;
    logic             key_valid_nxt;
    logic [3:0]       key_code_nxt;
    logic             multi_err_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sync    <= '0;
        end else begin
            sw_meta <= sw;
            sync    <= sw_meta;
        end
    end

    always_comb begin
        snap_index = '0;
        for (int i = 0; i < 10; i++) begin
            if (snapshot[i]) snap_index = 4'(i);
        end
    end

    assign snap_onehot = (snapshot != '0) && ((snapshot & (snapshot - 10'd1)) == '0);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        snapshot_nxt = snapshot;
        cnt_nxt      = cnt;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (sync != '0) begin
                    snapshot_nxt = sync;
                    cnt_nxt      = CNT_W'(1);
                    state_nxt    = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sync == snapshot) begin
                    if (cnt >= CNT_LAST) begin
                        accept    = 1'b1;
                        state_nxt = HELD;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if (sync == '0) begin
                    state_nxt = IDLE;
                end else begin
                    snapshot_nxt = sync;
                    cnt_nxt      = CNT_W'(1);
                end
            end
            HELD: begin
                // Nonzero changes while held are ignored; only a release moves on.
                if (sync == '0) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (sync != '0) begin
                    state_nxt = HELD;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        tenkey_nxt    = (accept && snap_onehot) ? snapshot : '0;
        key_valid_nxt = accept && snap_onehot;
        key_code_nxt  = (accept && snap_onehot) ? snap_index : 4'h0;
        multi_err_nxt = accept && !snap_onehot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            snapshot  <= '0;
            cnt       <= '0;
            tenkey    <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            multi_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            snapshot  <= snapshot_nxt;
            cnt       <= cnt_nxt;
            tenkey    <= tenkey_nxt;
            key_valid <= key_valid_nxt;
            key_code  <= key_code_nxt;
            multi_err <= multi_err_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tenkey_debounce.sv
// Bench for tenkey_debounce: run-length reference model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_tenkey_debounce;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sw = '0;
    logic [9:0] tenkey;
    logic       key_valid;
    logic [3:0] key_code;
    logic       multi_err;
    logic       busy;

    tenkey_debounce #(.DB_CYCLES(DB), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .tenkey    (tenkey),
        .key_valid (key_valid),
        .key_code  (key_code),
        .multi_err (multi_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [3:0] bit_index(logic [9:0] x);
        logic [3:0] r = 4'h0;
        for (int i = 0; i < 10; i++) if (x[i]) r = 4'(i);
        return r;
    endfunction

    // Reference model: what the FSM sees is sw delayed by two edges; a press is
    // accepted after DB identical nonzero samples, a release after DB zero samples.
    logic [9:0] m_q1 = '0, m_q2 = '0, m_val = '0;
    int         m_run = 0;
    bit         m_held = 1'b0;
    logic [9:0] exp_tenkey = '0;
    logic       exp_valid = 1'b0, exp_multi = 1'b0, exp_busy = 1'b0;
    logic [3:0] exp_code = 4'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q1 = '0; m_q2 = '0; m_val = '0; m_run = 0; m_held = 1'b0;
            exp_tenkey = '0; exp_valid = 1'b0; exp_code = 4'h0; exp_multi = 1'b0; exp_busy = 1'b0;
        end else begin
            logic [9:0] s;
            s = m_q2; m_q2 = m_q1; m_q1 = sw;
            exp_tenkey = '0; exp_valid = 1'b0; exp_code = 4'h0; exp_multi = 1'b0;
            if (!m_held) begin
                if (s == '0) m_run = 0;
                else if (m_run > 0 && s == m_val) m_run++;
                else begin m_val = s; m_run = 1; end
                if (m_run == DB) begin
                    if ($countones(m_val) == 1) begin
                        exp_tenkey = m_val; exp_valid = 1'b1; exp_code = bit_index(m_val);
                    end else begin
                        exp_multi = 1'b1;
                    end
                    m_held = 1'b1;
                    m_run  = 0;
                end
            end else begin
                if (s == '0) m_run++;
                else m_run = 0;
                if (m_run == DB) begin m_held = 1'b0; m_run = 0; end
            end
            exp_busy = m_held || (m_run > 0);
        end
    end

    always begin
        @(posedge clk);
        #1;
        check("tenkey",    32'(tenkey),    32'(exp_tenkey));
        check("key_valid", 32'(key_valid), 32'(exp_valid));
        check("key_code",  32'(key_code),  32'(exp_code));
        check("multi_err", 32'(multi_err), 32'(exp_multi));
        check("busy",      32'(busy),      32'(exp_busy));
    end

    // Pulse monitor used by the directed scenarios (read only at negedges).
    int         edge_no = 0;
    int         multi_cnt = 0;
    logic [3:0] codes[$];
    logic [9:0] tks[$];
    int         pulse_edges[$];

    always begin
        @(posedge clk);
        #1;
        edge_no++;
        if (key_valid) begin
            codes.push_back(key_code);
            tks.push_back(tenkey);
            pulse_edges.push_back(edge_no);
        end
        if (multi_err) multi_cnt++;
    end

    task automatic clear_mon();
        codes.delete(); tks.delete(); pulse_edges.delete(); multi_cnt = 0;
    endtask

    task automatic hold_sw(logic [9:0] v, int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sw = v;
        end
    endtask

    initial begin
        int         start;
        logic [9:0] v;
        int         hold;
        int         kind;

        repeat (3) @(negedge clk);
        check("reset_busy",   32'(busy), 32'(0));
        check("reset_tenkey", 32'(tenkey), 32'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press of key 7: pulse on the 6th edge after the change.
        clear_mon();
        start = edge_no;
        sw = 10'b0010000000;
        repeat (20) @(negedge clk);
        check("k7_pulses", 32'(codes.size()), 32'(1));
        check("k7_latency", 32'(pulse_edges.size() > 0 ? pulse_edges[0] - start : -1), 32'(6));
        check("k7_tenkey", 32'(tks.size() > 0 ? tks[0] : 10'h3ff), 32'h080);
        check("k7_code",   32'(codes.size() > 0 ? codes[0] : 4'hf), 32'd7);
        hold_sw('0, 12);

        // Toggling key 3 never settles; the stable hold afterwards yields one pulse.
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sw = (i % 2 == 0) ? 10'h008 : 10'h000;
        end
        check("toggle_silent", 32'(codes.size()), 32'(0));
        hold_sw(10'h008, 15);
        check("k3_pulses", 32'(codes.size()), 32'(1));
        check("k3_code", 32'(codes.size() > 0 ? codes[0] : 4'hf), 32'd3);
        hold_sw('0, 12);

        // Chord 0+7: one multi_err, no key, busy until DB zero samples seen.
        clear_mon();
        hold_sw(10'h081, 15);
        check("chord_multi", 32'(multi_cnt), 32'(1));
        check("chord_nokey", 32'(codes.size()), 32'(0));
        check("chord_busy_held", 32'(busy), 32'(1));
        sw = '0;
        repeat (4) @(negedge clk);
        check("chord_busy_release", 32'(busy), 32'(1));
        repeat (2) @(negedge clk);
        check("chord_idle", 32'(busy), 32'(0));
        hold_sw('0, 6);

        // Key 7, bouncy release, then key 3: exactly codes 7,3.
        clear_mon();
        hold_sw(10'h080, 10);
        hold_sw('0, 1); hold_sw(10'h080, 1); hold_sw('0, 1); hold_sw(10'h080, 1);
        hold_sw('0, 10);
        hold_sw(10'h008, 10);
        hold_sw('0, 10);
        check("seq_count", 32'(codes.size()), 32'(2));
        check("seq_first", 32'(codes.size() > 0 ? codes[0] : 4'hf), 32'd7);
        check("seq_second", 32'(codes.size() > 1 ? codes[1] : 4'hf), 32'd3);

        // Reset during debounce of key 5, key still held afterwards.
        clear_mon();
        sw = 10'h020;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_outputs", 32'({tenkey, key_valid, key_code, multi_err}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        start = edge_no;
        repeat (10) @(negedge clk);
        check("rst_pulses", 32'(codes.size()), 32'(1));
        check("rst_latency", 32'(pulse_edges.size() > 0 ? pulse_edges[0] - start : -1), 32'(DB + 2));
        check("rst_code", 32'(codes.size() > 0 ? codes[0] : 4'hf), 32'd5);
        hold_sw('0, 12);

        // Randomized traffic, checked by the per-cycle comparison against the model.
        for (int seg = 0; seg < 500; seg++) begin
            kind = $urandom_range(0, 19);
            hold = $urandom_range(1, DB + 6);
            if (kind < 9) begin
                v = 10'(1) << $urandom_range(0, 9);
                hold_sw(v, hold);
            end else if (kind < 12) begin
                v = 10'($urandom);
                hold_sw(v, hold);
            end else if (kind < 15) begin
                v = 10'(1) << $urandom_range(0, 9);
                for (int i = 0; i < hold; i++) hold_sw(($urandom_range(0, 1) == 1) ? v : 10'h000, 1);
            end else if (kind < 19) begin
                hold_sw('0, hold);
            end else begin
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        hold_sw('0, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
